alsa_capture: RTL

Capture-direction companion to the ALSA playback path. Collects 16-bit stereo PCM frames from the core at the 48 kHz sample strobe and packs two frames per 64-bit word. Writes the words into an HPS-owned DDR ring buffer over the Avalon-MM RAM port. The Linux driver configures the buffer over SPI and reads back the hardware write pointer in the same SPI transaction.

---
 rtl/alsa_pkg.sv | 26 ++
 rtl/alsa_spi_slave.sv | 98 +++++++++
 rtl/alsa_capture.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alsa_pkg.sv
// alsa_pkg: shared constants and types for the ALSA capture path.
//   ALSA_CFG_BYTES  length of the host->block configuration frame
//   ALSA_OFS_*      byte offsets of the little-endian 32-bit fields in that frame
//   ALSA_WORD_BYTES bytes per packed DDR word (two 16-bit stereo frames)
//   wr_state_t      Avalon writer FSM state
//   alsa_cfg_t      decoded configuration frame
package alsa_pkg;

  localparam int ALSA_CFG_BYTES  = 12;
  localparam int ALSA_OFS_ADDR   = 0;
  localparam int ALSA_OFS_LEN    = 4;
  localparam int ALSA_OFS_RPTR   = 8;
  localparam int ALSA_WORD_BYTES = 8;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] rptr;
  } alsa_cfg_t;

endpackage

// File: rtl/alsa_spi_slave.sv
// alsa_spi_slave: SPI mode-0 slave oversampled on ram_clk.
//   ram_clk, reset_n    clock / asynchronous active-low reset
//   spi_ss/sck/mosi     raw SPI pins (asynchronous, synchronized here)
//   spi_miso            registered SPI data to host
//   wptr                hardware write pointer, snapshotted when ss falls
//   cfg_commit          one-cycle strobe when byte 11 of a frame completes
//   cfg                 decoded frame, valid with cfg_commit
import alsa_pkg::*;

module alsa_spi_slave (
  input  logic        ram_clk,
  input  logic        reset_n,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] wptr,
  output logic        cfg_commit,
  output alsa_cfg_t   cfg
);

  localparam logic [3:0] LAST_BYTE = 4'(ALSA_CFG_BYTES - 1);
  localparam logic [3:0] SAT_BYTE  = 4'(ALSA_CFG_BYTES);

  // [1:0] are the synchronizer stages, [2] the previous synchronized value
  logic [2:0]  ss_sync, sck_sync;
  logic [1:0]  mosi_sync;
  logic        ss_s, mosi_s, sck_rise, sck_fall, ss_fall;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  rx_byte;
  logic [87:0] stage;
  logic [95:0] frame;
  logic [31:0] tx_sh, snap;

  assign ss_s     = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign ss_fall  = ss_sync[2] & ~ss_sync[1];
  assign rx_byte  = {rx_sh, mosi_s};
  assign frame    = {rx_byte, stage};
  // Byte 0 on the wire is the low byte of the pointer, each byte MSB-first
  assign snap     = {wptr[7:0], wptr[15:8], wptr[23:16], wptr[31:24]};

  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync    <= 3'b111;
      sck_sync   <= 3'b000;
      mosi_sync  <= 2'b00;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sh      <= '0;
      stage      <= '0;
      cfg        <= '0;
      cfg_commit <= 1'b0;
      tx_sh      <= '0;
      spi_miso   <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[1:0], spi_ss};
      sck_sync   <= {sck_sync[1:0], spi_sck};
      mosi_sync  <= {mosi_sync[0], spi_mosi};
      cfg_commit <= 1'b0;

      if (ss_s) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (sck_rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt < LAST_BYTE)
            stage[{byte_cnt, 3'b000} +: 8] <= rx_byte;
          // Fields change only here, so an aborted frame leaves cfg untouched
          if (byte_cnt == LAST_BYTE) begin
            cfg.addr   <= frame[ALSA_OFS_ADDR*8 +: 32];
            cfg.len    <= frame[ALSA_OFS_LEN*8 +: 32];
            cfg.rptr   <= frame[ALSA_OFS_RPTR*8 +: 32];
            cfg_commit <= 1'b1;
          end
          if (byte_cnt != SAT_BYTE)
            byte_cnt <= byte_cnt + 4'd1;
        end
      end

      // First bit is presented at select so the host can sample on edge 1
      if (ss_fall) begin
        spi_miso <= snap[31];
        tx_sh    <= {snap[30:0], 1'b0};
      end else if (!ss_s && sck_fall) begin
        spi_miso <= tx_sh[31];
        tx_sh    <= {tx_sh[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alsa_capture.sv
// alsa_capture: packs 16-bit stereo PCM frame pairs into 64-bit words and
// writes them into a DDR ring buffer over Avalon-MM; configured over SPI.
//   ram_clk, reset_n          clock / asynchronous active-low reset
//   ram_*                     Avalon-MM write master (burst of 1, all bytes)
//   spi_ss/sck/mosi/miso      configuration and write-pointer readback
//   pcm_ce, pcm_l, pcm_r      sample strobe and samples
//   overflow                  sticky: a packed word was dropped
//   wr_state                  writer FSM state (debug)
// Optional feature macro: ALSA_CAPTURE_OVF_EN -- hold writes while the next
// pointer would reach the host read pointer.
//
// Avalon handshake: ram_write is the request and stays asserted with stable
// address/data until a clock edge sees ram_waitrequest low; that edge is the
// accept, and only then is the FIFO head popped.
import alsa_pkg::*;

module alsa_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        ram_clk,
  input  logic        reset_n,
  output logic [28:0] ram_address,
  output logic [7:0]  ram_burstcount,
  input  logic        ram_waitrequest,
  output logic [63:0] ram_writedata,
  output logic [7:0]  ram_byteenable,
  output logic        ram_write,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        pcm_ce,
  input  logic [15:0] pcm_l,
  input  logic [15:0] pcm_r,
  output logic        overflow,
  output wr_state_t   wr_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        cfg_commit;
  alsa_cfg_t   cfg;
  logic [31:0] buf_addr, buf_len, host_rptr, buf_wptr, wptr_inc, wptr_sum;
  logic        rearm, enable, accept, host_full;
  logic        half_valid, inflight_stale;
  logic [31:0] half_word;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push_req, push, drop;
  wr_state_t   wr_next;
  logic        unused_rptr;

  alsa_spi_slave u_spi (
    .ram_clk    (ram_clk),
    .reset_n    (reset_n),
    .spi_ss     (spi_ss),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .wptr       (buf_wptr),
    .cfg_commit (cfg_commit),
    .cfg        (cfg)
  );

  assign ram_burstcount = 8'd1;
  assign ram_byteenable = 8'hFF;
  assign unused_rptr    = ^host_rptr;

  // Only a change of buffer geometry restarts the ring
  assign rearm  = cfg_commit && ((cfg.addr != buf_addr) || (cfg.len != buf_len));
  assign enable = |buf_len[31:3];
  assign accept = (wr_state == WR_WRITE) && !ram_waitrequest;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = pcm_ce && enable && half_valid && !rearm;
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  assign wptr_sum = buf_wptr + 32'(ALSA_WORD_BYTES);
  assign wptr_inc = (wptr_sum[31:3] >= buf_len[31:3]) ? 32'd0 : wptr_sum;

`ifdef ALSA_CAPTURE_OVF_EN
  assign host_full = (wptr_inc[31:3] == host_rptr[31:3]);
`else
  assign host_full = 1'b0;
`endif

  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_addr  <= '0;
      buf_len   <= '0;
      host_rptr <= '0;
    end else if (cfg_commit) begin
      buf_addr  <= cfg.addr;
      buf_len   <= cfg.len;
      host_rptr <= cfg.rptr;
    end
  end

  always_ff @(posedge ram_clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {pcm_r, pcm_l, half_word};
  end

  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_wptr       <= '0;
      overflow       <= 1'b0;
      half_valid     <= 1'b0;
      half_word      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      inflight_stale <= 1'b0;
    end else if (rearm) begin
      buf_wptr   <= '0;
      overflow   <= 1'b0;
      half_valid <= 1'b0;
      if (wr_state == WR_WRITE) begin
        // The word on the bus must finish; keep it as the only FIFO entry
        // and make sure its accept does not move the fresh pointer.
        if (accept) begin
          rd_ptr         <= rd_ptr + 1'b1;
          wr_ptr         <= rd_ptr + 1'b1;
          inflight_stale <= 1'b0;
        end else begin
          wr_ptr         <= rd_ptr + 1'b1;
          inflight_stale <= 1'b1;
        end
      end else begin
        wr_ptr <= rd_ptr;
      end
    end else begin
      if (pcm_ce && enable) begin
        if (!half_valid) begin
          half_word  <= {pcm_r, pcm_l};
          half_valid <= 1'b1;
        end else begin
          half_valid <= 1'b0;
        end
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (accept) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (inflight_stale)
          inflight_stale <= 1'b0;
        else
          buf_wptr <= wptr_inc;
      end
    end
  end

  // Writer FSM: state register
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n)
      wr_state <= WR_IDLE;
    else
      wr_state <= wr_next;
  end

  // Writer FSM: next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:  if (!empty && !rearm && !host_full) wr_next = WR_WRITE;
      WR_WRITE: if (accept) wr_next = WR_IDLE;
      default:  wr_next = WR_IDLE;
    endcase
  end

  // Writer FSM: outputs
  always_comb begin
    ram_write = (wr_state == WR_WRITE);
  end

  // Address and data are latched at request start so a stalled request
  // stays stable even if the configuration changes underneath it.
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_address   <= '0;
      ram_writedata <= '0;
    end else if (wr_state == WR_IDLE && wr_next == WR_WRITE) begin
      ram_address   <= buf_addr[31:3] + buf_wptr[31:3];
      ram_writedata <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule
